// File: rtl/mux_bist_pkg.sv
// Shared FSM state type and tap-map layout for the mux BIST scanner.
// Offsets beyond the data field depend on the select width, so they are constant functions.
package mux_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    WAIT,
    CMP,
    FIN
  } state_e;

  localparam int unsigned DATA_OFF = 0;

  function automatic int unsigned SEL_OFF(input int unsigned sel_w);
    return 2 ** sel_w;
  endfunction

  function automatic int unsigned DEC_OFF(input int unsigned sel_w);
    return (2 ** sel_w) + sel_w;
  endfunction

  function automatic int unsigned AND_OFF(input int unsigned sel_w);
    return 2 * (2 ** sel_w) + sel_w;
  endfunction

  function automatic int unsigned OUT_OFF(input int unsigned sel_w);
    return 3 * (2 ** sel_w) + sel_w;
  endfunction

endpackage

// File: rtl/mux_golden_model.sv
// Fault-free tap vector of a 2**SEL_W:1 AND-OR mux; doubles as a clean mux-under-test.
module mux_golden_model
  import mux_bist_pkg::*;
#(
  parameter int unsigned SEL_W = 1
) (
  input  logic [SEL_W-1:0]          i_sel,
  input  logic [2**SEL_W-1:0]       i_data,
  output logic [3*(2**SEL_W)+SEL_W:0] o_taps
);

  localparam int unsigned N     = 2 ** SEL_W;
  localparam int unsigned L_SEL = SEL_OFF(SEL_W);
  localparam int unsigned L_DEC = DEC_OFF(SEL_W);
  localparam int unsigned L_AND = AND_OFF(SEL_W);
  localparam int unsigned L_OUT = OUT_OFF(SEL_W);

  logic [N-1:0] w_dec;
  logic [N-1:0] w_and;

  always_comb begin
    w_dec        = '0;
    w_dec[i_sel] = 1'b1;
    w_and        = i_data & w_dec;

    o_taps                     = '0;
    o_taps[DATA_OFF +: N]      = i_data;
    o_taps[L_SEL +: SEL_W]     = i_sel;
    o_taps[L_DEC +: N]         = w_dec;
    o_taps[L_AND +: N]         = w_and;
    o_taps[L_OUT]              = |w_and;
  end

endmodule

// File: rtl/mux_bist_scanner.sv
// Exhaustive BIST sweep of a mux: applies every sel/data pattern, compares observed
// internal taps against the golden model and reports the first fault and a mismatch count.
module mux_bist_scanner
  import mux_bist_pkg::*;
#(
  parameter int unsigned SEL_W         = 1,
  parameter int unsigned SETTLE        = 1,
  parameter int unsigned STOP_ON_FAULT = 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  output logic [SEL_W-1:0]                        sel_o,
  output logic [2**SEL_W-1:0]                     data_o,
  input  logic [3*(2**SEL_W)+SEL_W:0]             taps_i,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    pass,
  output logic [$clog2(3*(2**SEL_W)+SEL_W+1)-1:0] fault_idx,
  output logic                                    fault_stuck,
  output logic [2**SEL_W+SEL_W-1:0]               fail_vec,
  output logic [15:0]                             err_count
);

  localparam int unsigned N     = 2 ** SEL_W;
  localparam int unsigned TAP_W = 3 * N + SEL_W + 1;
  localparam int unsigned PAT_W = N + SEL_W;
  localparam int unsigned IDX_W = $clog2(TAP_W);

  localparam logic [PAT_W-1:0] P_LAST    = '1;
  localparam logic [3:0]       WAIT_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

  state_e             r_state;
  state_e             w_state_next;
  logic [PAT_W-1:0]   r_p;
  logic [3:0]         r_wait_cnt;
  logic [SEL_W-1:0]   r_sel;
  logic [N-1:0]       r_data;
  logic               r_pass;
  logic [IDX_W-1:0]   r_fault_idx;
  logic               r_fault_stuck;
  logic [PAT_W-1:0]   r_fail_vec;
  logic [15:0]        r_err_count;

  logic [TAP_W-1:0]   w_golden;
  logic [TAP_W-1:0]   w_diff;
  logic               w_mismatch;
  logic               w_last;
  logic [IDX_W-1:0]   w_idx;

  mux_golden_model #(.SEL_W(SEL_W)) u_golden (
    .i_sel  (r_sel),
    .i_data (r_data),
    .o_taps (w_golden)
  );

  // Descending scan so the lowest differing tap is the one left in w_idx.
  always_comb begin
    w_diff     = taps_i ^ w_golden;
    w_mismatch = |w_diff;
    w_last     = (w_mismatch && (STOP_ON_FAULT != 0)) || (r_p == P_LAST);
    w_idx      = '0;
    for (int unsigned i = TAP_W; i > 0; i--) begin
      if (w_diff[i-1]) w_idx = IDX_W'(i - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_next = APPLY;
      APPLY:   w_state_next = (SETTLE == 0) ? CMP : WAIT;
      WAIT:    if (r_wait_cnt == WAIT_LAST) w_state_next = CMP;
      CMP:     w_state_next = w_last ? FIN : APPLY;
      FIN:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == APPLY) || (r_state == WAIT) || (r_state == CMP);
    done = (r_state == FIN);
  end

  // pass is resolved on the CMP->FIN edge so it is already valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p           <= '0;
      r_wait_cnt    <= '0;
      r_sel         <= '0;
      r_data        <= '0;
      r_pass        <= 1'b0;
      r_fault_idx   <= '0;
      r_fault_stuck <= 1'b0;
      r_fail_vec    <= '0;
      r_err_count   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_p           <= '0;
            r_pass        <= 1'b0;
            r_fault_idx   <= '0;
            r_fault_stuck <= 1'b0;
            r_fail_vec    <= '0;
            r_err_count   <= '0;
          end
        end
        APPLY: begin
          r_sel      <= r_p[SEL_W-1:0];
          r_data     <= r_p[PAT_W-1:SEL_W];
          r_wait_cnt <= '0;
        end
        WAIT: r_wait_cnt <= r_wait_cnt + 4'd1;
        CMP: begin
          if (w_mismatch) begin
            if (r_err_count == 16'd0) begin
              r_fault_idx   <= w_idx;
              r_fault_stuck <= taps_i[w_idx];
              r_fail_vec    <= r_p;
            end
            if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
          end
          if (w_last) r_pass <= (r_err_count == 16'd0) && !w_mismatch;
          else        r_p    <= r_p + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sel_o       = r_sel;
  assign data_o      = r_data;
  assign pass        = r_pass;
  assign fault_idx   = r_fault_idx;
  assign fault_stuck = r_fault_stuck;
  assign fail_vec    = r_fail_vec;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_mux_bist_scanner.sv
// Bench: two scanners (halt-on-fault and count-all) each driving a golden-model mux
// with injectable stuck-at taps; results are predicted by a behavioural sweep model.
module tb_mux_bist_scanner;

  localparam int SEL_W = 1;
  localparam int N     = 2;
  localparam int TAP_W = 8;
  localparam int NPAT  = 8;

  typedef struct {
    int         lat;
    logic       pass;
    logic [15:0] err;
    logic [2:0] idx;
    logic       st;
    logic [2:0] vec;
    logic       sel;
    logic [1:0] data;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;

  logic [7:0] fm [2];
  logic [7:0] fv [2];

  logic       sel_a, sel_b;
  logic [1:0] data_a, data_b;
  logic [7:0] gold_a, gold_b, taps_a, taps_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b, st_a, st_b;
  logic [2:0] idx_a, idx_b, vec_a, vec_b;
  logic [15:0] err_a, err_b;

  int checks = 0;
  int errors = 0;
  res_t got [2];
  int extra;

  always #5 clk = ~clk;

  assign taps_a = (gold_a & ~fm[0]) | (fv[0] & fm[0]);
  assign taps_b = (gold_b & ~fm[1]) | (fv[1] & fm[1]);

  mux_golden_model #(.SEL_W(SEL_W)) mut_a (.i_sel(sel_a), .i_data(data_a), .o_taps(gold_a));
  mux_golden_model #(.SEL_W(SEL_W)) mut_b (.i_sel(sel_b), .i_data(data_b), .o_taps(gold_b));

  mux_bist_scanner #(.SEL_W(1), .SETTLE(1), .STOP_ON_FAULT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .sel_o(sel_a), .data_o(data_a),
    .taps_i(taps_a), .busy(busy_a), .done(done_a), .pass(pass_a), .fault_idx(idx_a),
    .fault_stuck(st_a), .fail_vec(vec_a), .err_count(err_a)
  );

  mux_bist_scanner #(.SEL_W(1), .SETTLE(1), .STOP_ON_FAULT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .sel_o(sel_b), .data_o(data_b),
    .taps_i(taps_b), .busy(busy_b), .done(done_b), .pass(pass_b), .fault_idx(idx_b),
    .fault_stuck(st_b), .fail_vec(vec_b), .err_count(err_b)
  );

  // Fault-free value of tap t for pattern p, straight from the tap-map description.
  function automatic bit gold_tap(int p, int t);
    int sel = p % N;
    int dat = p / N;
    int k;
    if (t < N) return bit'((dat >> t) & 1);
    if (t < N + SEL_W) return bit'((sel >> (t - N)) & 1);
    if (t < 2 * N + SEL_W) return (sel == t - N - SEL_W);
    k = t - 2 * N - SEL_W;
    if (t < 3 * N + SEL_W) return (sel == k) && (((dat >> k) & 1) == 1);
    return bit'((dat >> sel) & 1);
  endfunction

  function automatic res_t model(logic [7:0] m, logic [7:0] v, bit stop);
    res_t e;
    int nvec = NPAT;
    int err = 0;
    bit mis;
    e.idx = '0; e.st = 1'b0; e.vec = '0;
    for (int p = 0; p < NPAT; p++) begin
      mis = 1'b0;
      for (int t = 0; t < TAP_W; t++) begin
        if (m[t] && (v[t] != gold_tap(p, t))) begin
          if (!mis && err == 0) begin
            e.idx = 3'(t); e.st = v[t]; e.vec = 3'(p);
          end
          mis = 1'b1;
        end
      end
      if (mis) err++;
      if (mis && stop) begin
        nvec = p + 1;
        break;
      end
    end
    e.err  = 16'(err);
    e.pass = (err == 0);
    e.lat  = nvec * 3 + 1;
    e.sel  = 1'((nvec - 1) % N);
    e.data = 2'((nvec - 1) / N);
    return e;
  endfunction

  task automatic run_sweep(input bit repulse);
    int c = 0;
    got[0].lat = -1;
    got[1].lat = -1;
    extra = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while ((got[0].lat < 0 || got[1].lat < 0) && c < 300) begin
      @(negedge clk);
      c++;
      if (done_a && got[0].lat < 0) begin
        got[0].lat = c; got[0].pass = pass_a; got[0].err = err_a; got[0].idx = idx_a;
        got[0].st = st_a; got[0].vec = vec_a; got[0].sel = sel_a; got[0].data = data_a;
      end
      if (done_b && got[1].lat < 0) begin
        got[1].lat = c; got[1].pass = pass_b; got[1].err = err_b; got[1].idx = idx_b;
        got[1].st = st_b; got[1].vec = vec_b; got[1].sel = sel_b; got[1].data = data_b;
      end
      start = repulse && (c == 10 || (done_a && done_b));
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy_a || busy_b || done_a || done_b) extra++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fm[0] = '0; fv[0] = '0; fm[1] = '0; fv[1] = '0;
    #12;
    checks++;
    if ({busy_a, done_a, pass_a, err_a, idx_a, st_a, vec_a, sel_a, data_a} !== '0) begin
      errors++;
      $display("FAIL reset_a: busy=%b done=%b pass=%b err=%0d idx=%0d vec=%0d sel=%b data=%b, all must be 0",
               busy_a, done_a, pass_a, err_a, idx_a, vec_a, sel_a, data_a);
    end
    checks++;
    if ({busy_b, done_b, pass_b, err_b, idx_b, st_b, vec_b, sel_b, data_b} !== '0) begin
      errors++;
      $display("FAIL reset_b: busy=%b done=%b pass=%b err=%0d idx=%0d vec=%0d sel=%b data=%b, all must be 0",
               busy_b, done_b, pass_b, err_b, idx_b, vec_b, sel_b, data_b);
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_against_model(input string name);
    res_t e;
    for (int d = 0; d < 2; d++) begin
      e = model(fm[d], fv[d], d == 0);
      checks++;
      if (got[d].lat !== e.lat) begin
        errors++;
        $display("FAIL %s dut%0d latency: got %0d expected %0d", name, d, got[d].lat, e.lat);
      end
      checks++;
      if ({got[d].pass, got[d].err} !== {e.pass, e.err}) begin
        errors++;
        $display("FAIL %s dut%0d pass/err: got %b/%0d expected %b/%0d", name, d,
                 got[d].pass, got[d].err, e.pass, e.err);
      end
      checks++;
      if ({got[d].idx, got[d].st, got[d].vec} !== {e.idx, e.st, e.vec}) begin
        errors++;
        $display("FAIL %s dut%0d fault idx/stuck/vec: got %0d/%b/%0d expected %0d/%b/%0d", name, d,
                 got[d].idx, got[d].st, got[d].vec, e.idx, e.st, e.vec);
      end
      checks++;
      if ({got[d].sel, got[d].data} !== {e.sel, e.data}) begin
        errors++;
        $display("FAIL %s dut%0d held vector sel/data: got %b/%b expected %b/%b", name, d,
                 got[d].sel, got[d].data, e.sel, e.data);
      end
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL %s idle_after_done: got %0d busy/done cycles expected 0", name, extra);
    end
  endtask

  task automatic test_fault_sweeps();
    logic [7:0] tm [6] = '{8'h00, 8'h80, 8'h02, 8'h04, 8'h20, 8'h11};
    logic [7:0] tv [6] = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h10};
    for (int i = 0; i < 6; i++) begin
      fm[0] = tm[i]; fv[0] = tv[i];
      fm[1] = tm[5 - i]; fv[1] = tv[5 - i];
      run_sweep(1'b0);
      check_against_model($sformatf("table%0d", i));
    end
    for (int i = 0; i < 10; i++) begin
      for (int d = 0; d < 2; d++) begin
        fm[d] = ($urandom_range(0, 3) == 0) ? 8'h00 : (8'h01 << $urandom_range(0, 7));
        if ($urandom_range(0, 4) == 0) fm[d] = fm[d] | (8'h01 << $urandom_range(0, 7));
        fv[d] = 8'($urandom);
      end
      run_sweep(1'b0);
      check_against_model($sformatf("rand%0d", i));
    end
  endtask

  task automatic test_spec_vectors();
    fm[0] = 8'h80; fv[0] = 8'h00;
    fm[1] = 8'h04; fv[1] = 8'h00;
    run_sweep(1'b0);
    checks++;
    if ({got[0].idx, got[0].st, got[0].vec, got[0].pass} !== {3'd7, 1'b0, 3'd2, 1'b0}) begin
      errors++;
      $display("FAIL out_sa0: idx/st/vec/pass got %0d/%b/%0d/%b expected 7/0/2/0",
               got[0].idx, got[0].st, got[0].vec, got[0].pass);
    end
    checks++;
    if ({got[1].err, got[1].vec, got[1].idx} !== {16'd4, 3'd1, 3'd2} || got[1].lat != 25) begin
      errors++;
      $display("FAIL sel_sa0_count: err/vec/idx/lat got %0d/%0d/%0d/%0d expected 4/1/2/25",
               got[1].err, got[1].vec, got[1].idx, got[1].lat);
    end
    fm[0] = 8'h02; fv[0] = 8'h02;
    fm[1] = 8'h00; fv[1] = 8'h00;
    run_sweep(1'b0);
    checks++;
    if ({got[0].idx, got[0].st, got[0].vec} !== {3'd1, 1'b1, 3'd0} || got[0].lat != 4) begin
      errors++;
      $display("FAIL data1_sa1: idx/st/vec/lat got %0d/%b/%0d/%0d expected 1/1/0/4",
               got[0].idx, got[0].st, got[0].vec, got[0].lat);
    end
    checks++;
    if (got[1].lat != 25 || got[1].pass !== 1'b1 || got[1].err !== 16'd0) begin
      errors++;
      $display("FAIL fault_free: lat/pass/err got %0d/%b/%0d expected 25/1/0",
               got[1].lat, got[1].pass, got[1].err);
    end
  endtask

  task automatic test_reset_midsweep();
    int dones = 0;
    fm[0] = 8'h80; fv[0] = 8'h00;
    fm[1] = 8'h04; fv[1] = 8'h00;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 11; c++) @(negedge clk);
    checks++;
    if (busy_b !== 1'b1 || err_b !== 16'd1) begin
      errors++;
      $display("FAIL pre_reset_b: busy/err got %b/%0d expected 1/1", busy_b, err_b);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_a, done_a, pass_a, err_a, idx_a, st_a, vec_a, sel_a, data_a} !== '0) begin
      errors++;
      $display("FAIL midreset_a: busy=%b pass=%b err=%0d idx=%0d vec=%0d sel=%b data=%b, all must be 0",
               busy_a, pass_a, err_a, idx_a, vec_a, sel_a, data_a);
    end
    checks++;
    if ({busy_b, done_b, pass_b, err_b, idx_b, st_b, vec_b, sel_b, data_b} !== '0) begin
      errors++;
      $display("FAIL midreset_b: busy=%b pass=%b err=%0d idx=%0d vec=%0d sel=%b data=%b, all must be 0",
               busy_b, pass_b, err_b, idx_b, vec_b, sel_b, data_b);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_a || done_b || busy_a || busy_b) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL no_done_after_reset: got %0d active cycles expected 0", dones);
    end
    fm[0] = '0; fm[1] = '0;
    run_sweep(1'b0);
    check_against_model("after_reset");
  endtask

  task automatic test_busy_restart();
    fm[0] = '0; fv[0] = '0; fm[1] = '0; fv[1] = '0;
    run_sweep(1'b1);
    checks++;
    if (got[0].lat != 25 || got[1].lat != 25) begin
      errors++;
      $display("FAIL restart_len: got %0d/%0d expected 25/25", got[0].lat, got[1].lat);
    end
    check_against_model("restart");
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_fault_sweeps();
    test_reset_midsweep();
    test_busy_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
